// File: rtl/hex_result_display_if.sv
// Bus between the RISC-V core and the result display stage: the core's
// result/instruction buses in, four seven-segment digits and status out.
interface hex_result_display_if;
  logic [31:0] result_i;
  logic [31:0] instruction_i;
  logic [6:0]  HEX0_D;
  logic [6:0]  HEX1_D;
  logic [6:0]  HEX2_D;
  logic [6:0]  HEX3_D;
  logic        halted_o;
  logic        page_o;

  // Core side: drives the buses, observes the display.
  modport master (
    output result_i, instruction_i,
    input  HEX0_D, HEX1_D, HEX2_D, HEX3_D, halted_o, page_o
  );

  // Display side: consumes the buses, drives digits and status.
  modport slave (
    input  result_i, instruction_i,
    output HEX0_D, HEX1_D, HEX2_D, HEX3_D, halted_o, page_o
  );
endinterface

// File: rtl/hex_result_display.sv
// Result display stage. Shows the live low half-word of the core result
// while running; once the halt word is fetched it freezes a snapshot and
// pages between its low and high half-words until reset.
module hex_result_display #(
  parameter int          PAGE_CYCLES = 25_000_000,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic                 CLK,
  input  logic                 RST,
  hex_result_display_if.slave  bus
);

  localparam int TW = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(PAGE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SHOW_LO = 2'd1,
    SHOW_HI = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [31:0]     snap_q,  snap_d;
  logic [15:0]     shown_d;
  logic [27:0]     hex_q,   hex_d;
  logic            halted_q, halted_d;
  logic            page_q,   page_d;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Next state, page timer and snapshot capture.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    timer_d = timer_q;
    snap_d  = snap_q;
    case (state_q)
      RUN: begin
        if (bus.instruction_i == HALT_WORD) begin
          snap_d  = bus.result_i;
          timer_d = '0;
          state_d = SHOW_LO;
        end
      end
      SHOW_LO: begin
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          state_d = SHOW_HI;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      SHOW_HI: begin
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          state_d = SHOW_LO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        timer_d = '0;
        state_d = RUN;
      end
    endcase
  end

  // Output values for the coming state, so the digits and status flip on
  // the same edge as the state itself.
  always_comb begin
    shown_d  = bus.result_i[15:0];
    halted_d = 1'b0;
    page_d   = 1'b0;
    case (state_d)
      SHOW_LO: begin
        shown_d  = snap_d[15:0];
        halted_d = 1'b1;
      end
      SHOW_HI: begin
        shown_d  = snap_d[31:16];
        halted_d = 1'b1;
        page_d   = 1'b1;
      end
      default: ;
    endcase
    hex_d = {seg7(shown_d[15:12]), seg7(shown_d[11:8]),
             seg7(shown_d[7:4]),   seg7(shown_d[3:0])};
  end

  // State, snapshot and registered outputs; reset blanks the digits.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state_q  <= RUN;
      timer_q  <= '0;
      snap_q   <= '0;
      hex_q    <= {4{7'h7F}};
      halted_q <= 1'b0;
      page_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      snap_q   <= snap_d;
      hex_q    <= hex_d;
      halted_q <= halted_d;
      page_q   <= page_d;
    end
  end

  assign bus.HEX0_D   = hex_q[6:0];
  assign bus.HEX1_D   = hex_q[13:7];
  assign bus.HEX2_D   = hex_q[20:14];
  assign bus.HEX3_D   = hex_q[27:21];
  assign bus.halted_o = halted_q;
  assign bus.page_o   = page_q;

endmodule

// File: tb/tb_hex_result_display.sv
// Bench for hex_result_display with a short page period. A cycle-level
// reference model tracks "halted", the snapshot and the number of cycles
// since capture; the shown page is derived from that count by division.
module tb_hex_result_display;
  localparam int P = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  hex_result_display_if bus ();

  hex_result_display #(.PAGE_CYCLES(P), .HALT_WORD(HALT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model state.
  bit          m_blank  = 1'b1;
  bit          m_halted = 1'b0;
  logic [31:0] m_snap   = '0;
  logic [15:0] m_live   = '0;
  int          m_cnt    = 0;

  function automatic logic [29:0] expected();
    logic [15:0] h;
    bit pg;
    if (m_blank) return {{4{7'h7F}}, 2'b00};
    pg = m_halted && ((m_cnt / P) % 2 == 1);
    h  = !m_halted ? m_live : (pg ? m_snap[31:16] : m_snap[15:0]);
    return {seg_tab[h[15:12]], seg_tab[h[11:8]], seg_tab[h[7:4]], seg_tab[h[3:0]],
            m_halted, pg};
  endfunction

  function automatic logic [29:0] actual();
    return {bus.HEX3_D, bus.HEX2_D, bus.HEX1_D, bus.HEX0_D, bus.halted_o, bus.page_o};
  endfunction

  // One clock edge: advance the model with the inputs the DUT samples,
  // then settle 1 time unit past the edge.
  task automatic step();
    @(posedge CLK);
    if (RST) begin
      m_blank = 1'b1; m_halted = 1'b0; m_snap = '0; m_cnt = 0;
    end else if (!m_halted) begin
      m_blank = 1'b0;
      m_live  = bus.result_i[15:0];
      if (bus.instruction_i == HALT) begin
        m_halted = 1'b1; m_snap = bus.result_i; m_cnt = 0;
      end
    end else begin
      m_cnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; bus.result_i = 32'h1234_5678; bus.instruction_i = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (actual() !== {{4{7'h7F}}, 2'b00}) begin
        errors++;
        $display("FAIL reset_state: got %h expected %h", actual(), {{4{7'h7F}}, 2'b00});
      end
    end
  endtask

  task automatic test_live();
    RST = 1'b0; bus.result_i = 32'h0000_BEEF; bus.instruction_i = '0;
    step();
    checks++;
    if (actual() !== {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110, 2'b00}) begin
      errors++;
      $display("FAIL live_beef: got %h expected %h", actual(),
               {7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110, 2'b00});
    end
    bus.result_i = 32'h0000_0123;
    step();
    checks++;
    if (actual() !== {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 2'b00}) begin
      errors++;
      $display("FAIL live_0123: got %h expected %h", actual(),
               {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 2'b00});
    end
    for (int i = 0; i < 6; i++) begin
      bus.result_i = $urandom;
      step();
      checks++;
      if (actual() !== expected()) begin
        errors++;
        $display("FAIL live_rand: got %h expected %h", actual(), expected());
      end
    end
  endtask

  task automatic test_halt();
    logic [29:0] lo_pat, hi_pat;
    lo_pat = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 2'b10};
    hi_pat = {7'b1000110, 7'b0001000, 7'b0001110, 7'b0000110, 2'b11};
    bus.result_i = 32'hCAFE_1234; bus.instruction_i = HALT;
    step();
    bus.result_i = '0; bus.instruction_i = '0;
    for (int i = 0; i < 3 * P; i++) begin
      checks++;
      if (actual() !== (((i / P) % 2 == 0) ? lo_pat : hi_pat)) begin
        errors++;
        $display("FAIL halt_page cycle %0d: got %h expected %h", i, actual(),
                 ((i / P) % 2 == 0) ? lo_pat : hi_pat);
      end
      checks++;
      if (actual() !== expected()) begin
        errors++;
        $display("FAIL halt_model cycle %0d: got %h expected %h", i, actual(), expected());
      end
      step();
    end
  endtask

  task automatic test_sticky();
    bus.result_i = 32'h5555_5555; bus.instruction_i = HALT;
    for (int i = 0; i < 2 * P + 1; i++) begin
      step();
      checks++;
      if (actual() !== expected()) begin
        errors++;
        $display("FAIL sticky cycle %0d: got %h expected %h", i, actual(), expected());
      end
    end
    bus.instruction_i = '0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2 * P && !((m_cnt / P) % 2 == 1); i++) step();
    checks++;
    if (bus.page_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre_page: got %b expected 1", bus.page_o);
    end
    RST = 1'b1;
    step();
    checks++;
    if (actual() !== {{4{7'h7F}}, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid_blank: got %h expected %h", actual(), {{4{7'h7F}}, 2'b00});
    end
    RST = 1'b0; bus.result_i = $urandom;
    step();
    checks++;
    if (actual() !== expected()) begin
      errors++;
      $display("FAIL reset_mid_live: got %h expected %h", actual(), expected());
    end
  endtask

  task automatic test_simultaneous();
    RST = 1'b1; bus.result_i = 32'hA5A5_0F0F; bus.instruction_i = HALT;
    step();
    checks++;
    if (actual() !== {{4{7'h7F}}, 2'b00}) begin
      errors++;
      $display("FAIL simul_reset_wins: got %h expected %h", actual(), {{4{7'h7F}}, 2'b00});
    end
    RST = 1'b0; bus.result_i = 32'h9D0C_8B7E;
    step();
    checks++;
    if (actual() !== {7'b0000000, 7'b0000011, 7'b1111000, 7'b0000110, 2'b10}) begin
      errors++;
      $display("FAIL simul_post_reset_halt: got %h expected %h", actual(),
               {7'b0000000, 7'b0000011, 7'b1111000, 7'b0000110, 2'b10});
    end
    bus.instruction_i = '0;
    for (int i = 0; i < P + 1; i++) begin
      step();
      checks++;
      if (actual() !== expected()) begin
        errors++;
        $display("FAIL simul_paging cycle %0d: got %h expected %h", i, actual(), expected());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      RST              = ($urandom_range(0, 24) == 0);
      bus.result_i     = $urandom;
      bus.instruction_i = ($urandom_range(0, 29) == 0) ? HALT : $urandom;
      step();
      checks++;
      if (actual() !== expected()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", i, actual(), expected());
      end
    end
  endtask

  initial begin
    bus.result_i = '0;
    bus.instruction_i = '0;
    test_reset();
    test_live();
    test_halt();
    test_sticky();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
